// File: rtl/alu_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_core
// Purpose  : Valid/ready multi-cycle ALU; single-cycle arith/logic/cmp/shift,
//            W-cycle shift-add multiply and optional restoring divide
//            (enabled by ALU_MC_DIV_EN).
// Revision : 1.0  initial release
// ============================================================================
module alu_mc_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [3:0]              alu_fun_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    arith_flag_o,
  output logic                    logic_flag_o,
  output logic                    cmp_flag_o,
  output logic                    shift_flag_o,
  output logic                    carry_o,
  output logic                    div_zero_o,
  output logic                    busy_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 16) ? $clog2(W) : 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d;
  logic [1:0]       unit_q, unit_d;
  logic             carry_q, carry_d;
  logic             divz_q, divz_d;

  logic             is_mul, is_div, accept;
  logic [W:0]       sum, diff, mul_sum;
  logic [2*W-1:0]   one_res, mul_next, step_next;
  logic             one_carry;

  assign is_mul = (alu_fun_i == 4'b0010);

  // Single-cycle units evaluate straight from the ports at the accept edge.
  always_comb begin
    sum       = {1'b0, a_i} + {1'b0, b_i};
    diff      = {1'b0, a_i} - {1'b0, b_i};
    one_res   = '0;
    one_carry = 1'b0;
    case (alu_fun_i)
      4'b0000: begin one_res[W-1:0] = sum[W-1:0];  one_carry = sum[W];  end
      4'b0001: begin one_res[W-1:0] = diff[W-1:0]; one_carry = diff[W]; end
      4'b0100: one_res[W-1:0] = a_i & b_i;
      4'b0101: one_res[W-1:0] = a_i | b_i;
      4'b0110: one_res[W-1:0] = ~(a_i & b_i);
      4'b0111: one_res[W-1:0] = ~(a_i | b_i);
      4'b1001: one_res[1:0]   = (a_i == b_i) ? 2'd1 : 2'd0;
      4'b1010: one_res[1:0]   = (a_i >  b_i) ? 2'd2 : 2'd0;
      4'b1011: one_res[1:0]   = (a_i <  b_i) ? 2'd3 : 2'd0;
      4'b1100: one_res[W-1:0] = a_i >> 1;
      4'b1101: one_res[W-1:0] = a_i << 1;
      4'b1110: one_res[W-1:0] = b_i >> 1;
      4'b1111: one_res[W-1:0] = b_i << 1;
      default: one_res = '0;
    endcase
  end

  // acc = {partial product high half, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, m_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

`ifdef ALU_MC_DIV_EN
  logic             div_q, div_d;
  logic [W:0]       div_shift;
  logic [W-1:0]     div_sub;
  logic             div_ge;

  assign is_div = (alu_fun_i == 4'b0011);

  // acc = {remainder, dividend bits shifting into quotient}; B==0 falls out
  // naturally as quotient all ones and remainder equal to A.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_sub   = div_shift[W-1:0] - m_q;
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign step_next = !div_q ? mul_next :
                     div_ge ? {div_sub, acc_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) div_q <= 1'b0;
    else         div_q <= div_d;
  end
`else
  assign is_div    = 1'b0;
  assign step_next = mul_next;
`endif

  assign in_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unit_d  = unit_q;
    carry_d = carry_q;
    divz_d  = divz_q;
`ifdef ALU_MC_DIV_EN
    div_d   = div_q;
`endif
    case (state_q)
      EXEC: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = DONE;
          res_d   = step_next;
        end
      end
      DONE:    if (out_ready_i && !in_valid_i) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      unit_d  = alu_fun_i[3:2];
      cnt_d   = '0;
      carry_d = 1'b0;
      divz_d  = 1'b0;
      if (is_mul || is_div) begin
        state_d = EXEC;
        m_d     = is_div ? b_i : a_i;
        acc_d   = {{W{1'b0}}, (is_div ? a_i : b_i)};
        divz_d  = is_div && (b_i == '0);
`ifdef ALU_MC_DIV_EN
        div_d   = is_div;
`endif
      end else begin
        state_d = DONE;
        res_d   = one_res;
        carry_d = one_carry;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      unit_q  <= '0;
      carry_q <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      unit_q  <= unit_d;
      carry_q <= carry_d;
      divz_q  <= divz_d;
    end
  end

  assign out_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign result_o     = res_q;
  assign arith_flag_o = out_valid_o & (unit_q == 2'b00);
  assign logic_flag_o = out_valid_o & (unit_q == 2'b01);
  assign cmp_flag_o   = out_valid_o & (unit_q == 2'b10);
  assign shift_flag_o = out_valid_o & (unit_q == 2'b11);
  assign carry_o      = out_valid_o & carry_q;
  assign div_zero_o   = out_valid_o & divz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc_core
// Purpose  : Self-checking bench for alu_mc_core against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc_core;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   a_in, b_in;
  logic [3:0]     alu_fun;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [2*W-1:0] result;
  logic           arith_flag, logic_flag, cmp_flag, shift_flag;
  logic           carry, div_zero, busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           carry;
    logic [1:0]     unit;
    logic           divz;
    logic [7:0]     lat;
  } exp_t;

  always #5 clk = ~clk;

  alu_mc_core #(.DATA_WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_i          (a_in),
    .b_i          (b_in),
    .alu_fun_i    (alu_fun),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .result_o     (result),
    .arith_flag_o (arith_flag),
    .logic_flag_o (logic_flag),
    .cmp_flag_o   (cmp_flag),
    .shift_flag_o (shift_flag),
    .carry_o      (carry),
    .div_zero_o   (div_zero),
    .busy_o       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome from plain integer arithmetic; lat counts negedges from
  // the command setup edge until OUT_VALID is seen.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, m, r;
    ua = longint'(a);
    ub = longint'(b);
    m  = longint'(1) << W;
    r  = 0;
    e.carry = 1'b0;
    e.divz  = 1'b0;
    e.unit  = op[3:2];
    e.lat   = 8'd1;
    case (op)
      4'd0:  begin r = (ua + ub) % m; e.carry = ((ua + ub) >= m); end
      4'd1:  begin r = (ua - ub + m) % m; e.carry = (ua < ub); end
      4'd2:  begin r = ua * ub; e.lat = 8'(W + 1); end
      4'd3: begin
`ifdef ALU_MC_DIV_EN
        e.lat = 8'(W + 1);
        if (ub == 0) begin r = (ua << W) + (m - 1); e.divz = 1'b1; end
        else         r = ((ua % ub) << W) + (ua / ub);
`else
        r = 0;
`endif
      end
      4'd4:  r = ua & ub;
      4'd5:  r = ua | ub;
      4'd6:  r = m - 1 - (ua & ub);
      4'd7:  r = m - 1 - (ua | ub);
      4'd8:  r = 0;
      4'd9:  r = (ua == ub) ? 1 : 0;
      4'd10: r = (ua >  ub) ? 2 : 0;
      4'd11: r = (ua <  ub) ? 3 : 0;
      4'd12: r = ua / 2;
      4'd13: r = (ua * 2) % m;
      4'd14: r = ub / 2;
      default: r = (ub * 2) % m;
    endcase
    e.res = r[2*W-1:0];
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, "/valid"},  64'(out_valid), 64'(1));
    check_eq({tag, "/result"}, 64'(result), 64'(e.res));
    check_eq({tag, "/flags"},  64'({arith_flag, logic_flag, cmp_flag, shift_flag}), 64'(4'b1000 >> e.unit));
    check_eq({tag, "/carry"},  64'(carry), 64'(e.carry));
    check_eq({tag, "/divz"},   64'(div_zero), 64'(e.divz));
  endtask

  // Issue one command with OUT_READY=1, scramble inputs after accept, wait
  // (bounded) for the result, then confirm OUT_VALID drops.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int   lat;
    e = model(op, a, b);
    @(negedge clk);
    alu_fun = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        alu_fun  = 4'($urandom);
        if (e.lat > 1) begin
          check_eq({tag, "/exec_ready"}, 64'(in_ready), 64'(0));
          check_eq({tag, "/exec_busy"},  64'(busy), 64'(1));
        end
      end
    end while (!out_valid && lat < 3 * W);
    check_eq({tag, "/latency"}, 64'(lat), 64'(e.lat));
    check_outputs(tag, e);
    @(negedge clk);
    check_eq({tag, "/drop"}, 64'({out_valid, arith_flag, logic_flag, cmp_flag, shift_flag}), 64'(0));
  endtask

  initial begin
    exp_t       e;
    logic [3:0] ops [3];
    logic [3:0] op;
    logic [W-1:0] ra, rb, ra2, rb2;
    int         seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; alu_fun = '0;
    repeat (3) @(negedge clk);
    check_eq("rst/ready",  64'(in_ready), 64'(0));
    check_eq("rst/valid",  64'(out_valid), 64'(0));
    check_eq("rst/busy",   64'(busy), 64'(0));
    check_eq("rst/result", 64'(result), 64'(0));
    check_eq("rst/flags",  64'({arith_flag, logic_flag, cmp_flag, shift_flag, carry, div_zero}), 64'(0));
    rst_n = 1'b1;
    #1;
    check_eq("rel/ready", 64'(in_ready), 64'(1));

    run_op(4'b0000, 16'hFFFF, 16'h0001, "add_wrap");
    run_op(4'b0001, 16'h0003, 16'h0005, "sub_borrow");
    run_op(4'b0010, 16'h1234, 16'h0100, "mul");
    run_op(4'b0010, 16'hFFFF, 16'hFFFF, "mul_max");
    run_op(4'b0011, 16'd100,  16'd7,    "div");
    run_op(4'b0011, 16'h1234, 16'h0000, "div_zero");
    run_op(4'b1011, 16'h0001, 16'h0002, "cmp_lt");

    // Back-to-back stream, one result per cycle
    ops[0] = 4'b0100; ops[1] = 4'b1001; ops[2] = 4'b1101;
    @(negedge clk);
    a_in = 16'h00F0; b_in = 16'h00F0; alu_fun = ops[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = model(ops[i], 16'h00F0, 16'h00F0);
      check_outputs($sformatf("stream%0d", i), e);
      check_eq($sformatf("stream%0d/ready", i), 64'(in_ready), 64'(1));
      if (i < 2) alu_fun = ops[i + 1];
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("stream/drop", 64'(out_valid), 64'(0));

    // Back-pressure hold, then hand-off on the release edge
    ra = W'($urandom); rb = W'($urandom); ra2 = W'($urandom); rb2 = W'($urandom);
    @(negedge clk);
    alu_fun = 4'b0000; a_in = ra; b_in = rb; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    alu_fun = 4'b0001; a_in = ra2; b_in = rb2;
    e = model(4'b0000, ra, rb);
    for (int i = 0; i < 5; i++) begin
      check_outputs($sformatf("hold%0d", i), e);
      check_eq($sformatf("hold%0d/ready", i), 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_outputs("handoff", model(4'b0001, ra2, rb2));
    @(negedge clk);
    check_eq("handoff/drop", 64'(out_valid), 64'(0));

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(op, ra, rb, $sformatf("rnd%0d_op%0d", n, op));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    alu_fun = 4'b0010; a_in = W'($urandom); b_in = W'($urandom); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("abort/busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("abort/outs", 64'({out_valid, busy, in_ready, arith_flag, carry, div_zero}), 64'(0));
    check_eq("abort/result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("abort/ready", 64'(in_ready), 64'(1));
    check_eq("abort/busy",  64'(busy), 64'(0));
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort/stale_valid", 64'(seen), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
